// File: rtl/seqdet_pkg.sv
// rtl/seqdet_pkg.sv - shared defaults and width helper for the serial sequence detector
package seqdet_pkg;

    localparam int DEFAULT_MAX_LEN = 8;
    localparam int DEFAULT_CNT_W   = 8;

    // Bits needed to hold any value 0..max_len inclusive.
    function automatic int len_width(input int max_len);
        return $clog2(max_len + 1);
    endfunction

endpackage

// File: rtl/seqdet_history.sv
// rtl/seqdet_history.sv - serial history shift register and saturating fill count
module seqdet_history
    import seqdet_pkg::*;
#(
    parameter int MAX_LEN = DEFAULT_MAX_LEN,
    localparam int LEN_W  = len_width(MAX_LEN)
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               EN,
    input  logic               X,
    input  logic               CLR_FILL,
    output logic [MAX_LEN-1:0] HIST,
    output logic [LEN_W-1:0]   FILL
);

    localparam logic [LEN_W-1:0] FILL_FULL = LEN_W'(MAX_LEN);

    logic [MAX_LEN-1:0] r_hist;
    logic [LEN_W-1:0]   r_fill;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_hist <= '0;
            r_fill <= '0;
        end else if (EN) begin
            r_hist <= {r_hist[MAX_LEN-2:0], X};
            // A non-overlapping match restarts the count but keeps the old bits.
            if (CLR_FILL) begin
                r_fill <= '0;
            end else if (r_fill != FILL_FULL) begin
                r_fill <= r_fill + 1'b1;
            end
        end
    end

    assign HIST = r_hist;
    assign FILL = r_fill;

endmodule

// File: rtl/seq_detector_param.sv
// rtl/seq_detector_param.sv - programmable serial pattern detector; optional match counter via SEQDET_COUNT_EN
module seq_detector_param
    import seqdet_pkg::*;
#(
    parameter int MAX_LEN = DEFAULT_MAX_LEN,
    parameter int CNT_W   = DEFAULT_CNT_W,
    localparam int LEN_W  = len_width(MAX_LEN)
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               EN,
    input  logic               X,
    input  logic [MAX_LEN-1:0] PAT,
    input  logic [LEN_W-1:0]   LEN,
    input  logic               OVERLAP,
    output logic               Y
`ifdef SEQDET_COUNT_EN
    ,
    output logic [CNT_W-1:0]   CNT
`endif
);

    localparam logic [LEN_W-1:0] FILL_FULL = LEN_W'(MAX_LEN);

    logic [MAX_LEN-1:0] w_hist;
    logic [LEN_W-1:0]   w_fill;
    logic [MAX_LEN-1:0] w_hist_next;
    logic [LEN_W-1:0]   w_fill_next;
    logic [MAX_LEN-1:0] w_mask;
    logic               w_len_ok;
    logic               w_match;
    logic               w_clr_fill;
    logic               r_y;

    generate
        if (MAX_LEN < 2 || MAX_LEN > 32 || CNT_W < 1 || CNT_W > 32) begin : g_param_out_of_range
        end
    endgenerate

    seqdet_history #(
        .MAX_LEN (MAX_LEN)
    ) u_history (
        .CLK      (CLK),
        .RST      (RST),
        .EN       (EN),
        .X        (X),
        .CLR_FILL (w_clr_fill),
        .HIST     (w_hist),
        .FILL     (w_fill)
    );

    // Match is judged on the post-edge history, so mirror the history update here.
    assign w_hist_next = {w_hist[MAX_LEN-2:0], X};
    assign w_fill_next = (w_fill == FILL_FULL) ? w_fill : w_fill + 1'b1;
    assign w_mask      = ~({MAX_LEN{1'b1}} << LEN);
    assign w_len_ok    = (LEN != '0) && (LEN <= FILL_FULL);
    assign w_match     = EN && w_len_ok && (w_fill_next >= LEN)
                       && ((w_hist_next & w_mask) == (PAT & w_mask));
    assign w_clr_fill  = w_match && !OVERLAP;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_y <= 1'b0;
        end else begin
            r_y <= w_match;
        end
    end

    assign Y = r_y;

`ifdef SEQDET_COUNT_EN
    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_cnt <= '0;
        end else if (w_match && (r_cnt != {CNT_W{1'b1}})) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign CNT = r_cnt;
`endif

endmodule

// File: tb/tb_seq_detector_param.sv
// tb/tb_seq_detector_param.sv - bench for seq_detector_param against a bit-queue reference model
module tb_seq_detector_param;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       EN = 1'b0;
    logic       X = 1'b0;
    logic [7:0] PAT = 8'h00;
    logic [3:0] LEN = 4'd0;
    logic       OVERLAP = 1'b1;
    logic       Y;

    int n_checks = 0;
    int n_errors = 0;

    bit q[$];
    int since = 0;
    int exp_cnt = 0;

`ifdef SEQDET_COUNT_EN
    logic [7:0] CNT;
    logic [7:0] PAT2 = 8'h01;
    logic [3:0] LEN2 = 4'd1;
    logic       OVL2 = 1'b1;
    logic       Y2;
    logic [1:0] CNT2;
`endif

    always #5 CLK = ~CLK;

    seq_detector_param u_dut (
        .CLK     (CLK),
        .RST     (RST),
        .EN      (EN),
        .X       (X),
        .PAT     (PAT),
        .LEN     (LEN),
        .OVERLAP (OVERLAP),
        .Y       (Y)
`ifdef SEQDET_COUNT_EN
        ,
        .CNT     (CNT)
`endif
    );

`ifdef SEQDET_COUNT_EN
    seq_detector_param #(.MAX_LEN(8), .CNT_W(2)) u_dut2 (
        .CLK     (CLK),
        .RST     (RST),
        .EN      (EN),
        .X       (X),
        .PAT     (PAT2),
        .LEN     (LEN2),
        .OVERLAP (OVL2),
        .Y       (Y2),
        .CNT     (CNT2)
    );
`endif

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Reference: keep the last 8 received bits and how many arrived since the last clear.
    task automatic step(input bit en, input bit x, input string tag);
        bit exp_y;
        bit ok;
        int l;
        EN = en;
        X = x;
        exp_y = 1'b0;
        l = int'(LEN);
        if (en) begin
            q.push_back(x);
            if (q.size() > 8) void'(q.pop_front());
            since++;
            if (l >= 1 && l <= 8 && since >= l) begin
                ok = 1'b1;
                for (int k = 0; k < l; k++)
                    if (q[q.size() - 1 - k] != PAT[k]) ok = 1'b0;
                exp_y = ok;
            end
            if (exp_y) begin
                if (exp_cnt < 255) exp_cnt++;
                if (!OVERLAP) since = 0;
            end
        end
        @(posedge CLK);
        #1;
        check({tag, ".y"}, 32'(Y), 32'(exp_y));
`ifdef SEQDET_COUNT_EN
        check({tag, ".cnt"}, 32'(CNT), 32'(exp_cnt));
`endif
        @(negedge CLK);
    endtask

    task automatic do_reset(input string tag);
        #1 RST = 1'b1;
        #1;
        check({tag, ".rst_y"}, 32'(Y), 32'd0);
`ifdef SEQDET_COUNT_EN
        check({tag, ".rst_cnt"}, 32'(CNT), 32'd0);
`endif
        RST = 1'b0;
        q.delete();
        since = 0;
        exp_cnt = 0;
    endtask

    task automatic feed(input logic [31:0] bits, input int n, input string tag);
        for (int i = n - 1; i >= 0; i--) step(1'b1, bits[i], tag);
    endtask

    initial begin
        @(posedge CLK);
        #1;
        check("por_y", 32'(Y), 32'd0);
        @(negedge CLK);
        RST = 1'b0;

        PAT = 8'b0000_1101; LEN = 4'd4; OVERLAP = 1'b1;
        feed(32'b1101101, 7, "ovl1");
        do_reset("r1");
        OVERLAP = 1'b0;
        feed(32'b1101101, 7, "ovl0");

        do_reset("r2");
        OVERLAP = 1'b1;
        feed(32'b110, 3, "pre_rst");
        do_reset("r3");
        feed(32'b1, 1, "post_rst");
        feed(32'b1101, 4, "after_rst");

        do_reset("r4");
        feed(32'b110, 3, "gap_a");
        step(1'b0, 1'b1, "gap_off1");
        step(1'b0, 1'b0, "gap_off2");
        step(1'b1, 1'b1, "gap_b");

        do_reset("r5");
        LEN = 4'd0;
        for (int i = 0; i < 12; i++) step(1'b1, 1'(i % 2), "len0");
        LEN = 4'd8; PAT = 8'hA5;
        do_reset("r6");
        feed(32'b10100101, 8, "len8");
        LEN = 4'd9;
        feed(32'b10100101, 8, "len9");

`ifdef SEQDET_COUNT_EN
        do_reset("r7");
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 1'b1, "sat");
            check("sat.y2", 32'(Y2), 32'd1);
            check("sat.cnt2", 32'(CNT2), (i < 3) ? 32'(i + 1) : 32'd3);
        end
`endif

        do_reset("r8");
        LEN = 4'd3; PAT = 8'($urandom);
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 15) == 0) begin
                LEN = 4'($urandom_range(0, 9));
                PAT = 8'($urandom);
            end
            if ($urandom_range(0, 7) == 0) OVERLAP = 1'($urandom);
            if ($urandom_range(0, 79) == 0) do_reset("rnd_rst");
            step($urandom_range(0, 3) != 0, 1'($urandom), "rnd");
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
